pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; curPC value loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 nextPC  input  32  next-instruction address from the PC-select logic.
REQ-005 PCWre  input  1  PC write enable from control unit; 0 = stall (re-fetch same PC).
REQ-006 curPC  output  32  address of the instruction currently fetched or held.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  request address; always equals curPC.
REQ-009 imem_gnt  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instr  output  32  held instruction for decode.
REQ-013 instr_valid  output  1  instr is valid and awaiting acceptance.
REQ-014 instr_ack  input  1  decode/execute consumes instr this cycle.
REQ-015 misalign  output  1  sticky: fetch stopped on non-word-aligned PC.
REQ-016 instr_count  output  32  number of completed instr handshakes.

Function
REQ-017 FSM states FETCH, WAIT, HOLD, HALT; reset state FETCH.
REQ-018 FETCH: imem_req=1; on imem_gnt=1 go to WAIT next cycle, else remain.
REQ-019 WAIT: imem_req=0; on imem_rvalid=1 capture imem_rdata into instr, go to HOLD; imem_rvalid outside WAIT ignored.
REQ-020 HOLD: instr_valid=1; instr stable until handshake; on instr_ack=1 handshake completes.
REQ-021 On completed handshake with PCWre=1: curPC<=nextPC; with PCWre=0: curPC unchanged; instr_count+1 in both cases.
REQ-022 After handshake: if the PC to be fetched next has bits [1:0]!=0, go to HALT and set misalign; otherwise go to FETCH.
REQ-023 HALT: imem_req=0, instr_valid=0, curPC holds the misaligned value; exit only by Reset.
REQ-024 instr_ack outside HOLD has no effect; nextPC/PCWre sampled only at the handshake edge.
REQ-025 Minimum loop latency: gnt in cycle N, rvalid in N+1, instr_valid in N+2, ack in N+2, imem_req in N+3 at new PC (3 cycles/instruction).
REQ-026 instr_count wraps 32'hFFFF_FFFF -> 0 without flag.
REQ-027 Reset asserted in any state overrides every other input in that cycle.

Reset
REQ-028 On Reset: curPC=RESET_PC, state=FETCH, instr=32'h0, instr_valid=0, misalign=0, instr_count=0.
REQ-029 imem_req=1 in the first cycle after Reset deasserts; outstanding memory responses are discarded (memory shares Reset).
REQ-030 RESET_PC with bits [1:0]!=0 is a configuration error; behaviour undefined.

Structure
REQ-031 Shared package cpu_pkg holds the fetch-state enum, WORD_BYTES=4, and the default RESET_PC.
REQ-032 One sub-module, pc_register: 32-bit register with synchronous reset value and load enable; FSM and counter stay in pc_fetch_unit.

Verification
REQ-033 Reset, gnt=1 immediately, rvalid next cycle with rdata=32'h2001_0005, ack at once -> instr=32'h2001_0005 valid 2 cycles after gnt, curPC 0->nextPC=32'h4, instr_count=1.
REQ-034 gnt held low 5 cycles -> imem_req stays 1, imem_addr stable at 32'h0, no state change.
REQ-035 HOLD with ack low 4 cycles, then ack with PCWre=0, nextPC=32'h40 -> instr stable throughout, curPC stays 32'h0, re-fetch of 32'h0, count=1.
REQ-036 Handshake with PCWre=1, nextPC=32'h0000_0042 -> HALT, misalign=1, imem_req=0, curPC=32'h42; later gnt/rvalid ignored.
REQ-037 Reset asserted while in WAIT, rvalid arriving in same cycle -> all outputs at reset values next cycle, instr=0, request at RESET_PC.
REQ-038 Force instr_count to 32'hFFFF_FFFF, complete one handshake -> instr_count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: FSM state encoding, word geometry, default reset PC.
package cpu_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam int          ALIGN_BITS       = $clog2(WORD_BYTES);
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // True when the address is not on a word boundary.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[ALIGN_BITS-1:0] != '0;
    endfunction

endpackage

// File: rtl/pc_register.sv
// 32-bit program counter register: synchronous reset to a fixed value, load enable.
module pc_register #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // Reset wins; otherwise load only when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i)       pc_q <= RESET_VAL;
        else if (load_i) pc_q <= d_i;
    end

    assign q_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: request at curPC, wait for data, hold it for decode,
// advance (or stall) the PC on handshake, halt on a misaligned next PC.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] nextPC,
    input  logic        PCWre,
    output logic [31:0] curPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic        misalign,
    output logic [31:0] instr_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_count_q;
    logic         misalign_q;
    logic         handshake;
    logic [31:0]  pc_after;

    // PC the next fetch would use if a handshake completes now.
    assign pc_after = PCWre ? nextPC : curPC;

    pc_register #(.RESET_VAL(RESET_PC)) u_pc (
        .clk_i  (CLK),
        .rst_i  (Reset),
        .load_i (handshake && PCWre),
        .d_i    (nextPC),
        .q_o    (curPC)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        handshake   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    handshake = 1'b1;
                    state_d   = pc_misaligned(pc_after) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Capture read data only while waiting for it; stray responses are dropped.
    always_ff @(posedge CLK) begin
        if (Reset)                                instr_q <= 32'h0;
        else if (state_q == ST_WAIT && imem_rvalid) instr_q <= imem_rdata;
    end

    // Sticky misalign flag and wrapping handshake counter.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            misalign_q    <= 1'b0;
            instr_count_q <= 32'h0;
        end else if (handshake) begin
            instr_count_q <= instr_count_q + 32'd1;
            if (pc_misaligned(pc_after)) misalign_q <= 1'b1;
        end
    end

    assign imem_addr   = curPC;
    assign instr       = instr_q;
    assign misalign    = misalign_q;
    assign instr_count = instr_count_q;

endmodule
